round_key_sequencer: RTL and testbench
======================================

// Module: round_key_sequencer
// PURPOSE
//  Downstream of the key expansion block. Captures the packed expanded-key vector on key_done
//  and holds it in a shadow register. Serves one 128-bit round key per beat to the cipher round
//  datapath over a valid/ready handshake. The held keys are replayed for every new block, so
//  expansion runs once per key, not once per block.
// PARAMETERS
//  KW_W   1920  width of packed expanded-key vector (15 keys x 128b max)
//  RK_W   128   width of one round key
//  RND_W  4     width of round index
// PORTS
//  eph1         in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; clears all state and outputs
//  key_done     in   1      one-cycle pulse: key_words/key_size valid, capture them
//  key_size     in   2      00=128b (NR=10), 01=192b (NR=12), 1x=256b (NR=14)
//  key_words    in   KW_W   packed round keys; round i key = key_words[(NR-i)*128 +: 128]
//  start        in   1      pulse: begin issuing round keys for one block
//  rk_ready     in   1      round datapath accepts current beat
//  rk_valid     out  1      rk_data/rk_round/rk_last valid
//  rk_data      out  RK_W   current round key
//  rk_round     out  RND_W  index of current round key
//  rk_last      out  1      current beat is the final round key
//  keys_loaded  out  1      shadow register holds a valid key set
//  busy         out  1      issuing in progress
//  done         out  1      one-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; shadow key, key_size and round counter cleared.
//  - All outputs registered. No combinational in->out paths.
//  - FSM states:
//      IDLE   -> LOADED on key_done
//      LOADED -> ISSUE on start
//      ISSUE  -> DONE when the rk_last beat is accepted (rk_valid & rk_ready)
//      DONE   -> LOADED unconditionally after 1 cycle; done=1 in this cycle only
//  - Capture: key_done in any state latches key_words and key_size next edge; keys_loaded=1 from
//    then on.
//  - key_done in ISSUE/DONE aborts: next cycle rk_valid=0, state LOADED, no done pulse.
//  - key_done and start in the same cycle: key_done wins, start ignored.
//  - start is ignored in IDLE, ISSUE and DONE. It is not queued.
//  - Latency: start at edge T -> rk_valid=1 with rk_round=0 after edge T+1.
//  - Handshake: a beat advances only on rk_valid & rk_ready. While rk_valid & ~rk_ready,
//    rk_data, rk_round and rk_last are held stable. With rk_ready held at 1, one beat per cycle,
//    no bubbles.
//  - rk_round runs 0..NR. rk_last = (rk_round==NR). rk_valid drops the cycle after rk_last is
//    accepted.
//  - NR is derived from the captured key_size, never the live input. key_size=11 is treated as
//    256b.
//  - Unused upper key_words bits (128b/192b) are captured and never issued.
//  - busy=1 in ISSUE only.
//  - reset mid-ISSUE: outputs cleared immediately (async). Keys are lost; key_done is required
//    again.
// CONFIGURATION
//  RK_REVERSE_EN defined:
//    - Adds input port dec (1b), sampled on an accepted start.
//    - dec=1: issue rk_round NR down to 0; rk_last on round 0. This is the decryption order.
//    - dec=0: normal order.
//  RK_REVERSE_EN undefined:
//    - No dec port. Ascending order only.
// TESTING
//  1 128b FIPS key 2b7e151628aed2a6abf7158809cf4f3c, key_done, start, rk_ready=1:
//    - 11 back-to-back beats.
//    - r0=2b7e1516..4f3c, r1=a0fafe1788542cb123a339392a6c7605, r10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//    - rk_last on r10; done pulses the next cycle; state returns to LOADED.
//  2 Backpressure on test 1: rk_ready pattern 1,0,0,1 at r3:
//    - r3 held 3 cycles with identical data.
//    - Total beats still 11; no duplicate or skipped index.
//  3 256b key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//    - 15 beats.
//    - r0=603deb1015ca71be2b73aef0857d7781, r1=1f352c073b6108d72d9810a30914dff4, rk_last at 14.
//  4 key_done pulse while issuing r5:
//    - rk_valid=0 next cycle, no done pulse.
//    - A new start issues r0 of the new key.
//    - key_done+start in the same cycle: start ignored.
//  5 reset asserted mid-ISSUE between clock edges:
//    - All outputs 0 before the next edge; keys_loaded=0.
//    - start after reset deassertion ignored (IDLE).
//  6 RK_REVERSE_EN, 128b key, dec=1:
//    - First beat d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_round=10.
//    - Last beat 2b7e1516..4f3c with rk_round=0 and rk_last=1.

Source files
------------

// File: rtl/round_key_sequencer.sv
// ---------------------------------------------------------------------------------------------
// round_key_sequencer
//
// Sits downstream of the key expansion block. On a key_done pulse the packed expanded-key vector
// and the key size are captured into a shadow register. Each start pulse then replays the held
// round keys, one 128-bit key per beat, to the cipher round datapath over a valid/ready
// handshake. Expansion therefore runs once per key rather than once per block.
//
// Optional feature (macro RK_REVERSE_EN):
//   defined   : adds input dec_i, sampled on an accepted start. dec_i=1 issues rounds NR down
//               to 0 (decryption order, rk_last on round 0); dec_i=0 issues 0 up to NR.
//   undefined : no dec_i port, ascending order only.
//
// Ports
//   eph1_i         clock, all state on the rising edge
//   reset_i        asynchronous, active-high; clears all state and outputs
//   key_done_i     one-cycle pulse, capture key_words_i / key_size_i
//   key_size_i     00 = 128b (NR=10), 01 = 192b (NR=12), 1x = 256b (NR=14)
//   key_words_i    packed round keys, round i at [(NR-i)*RK_W +: RK_W]
//   start_i        pulse, issue the round keys for one block (honoured in LOADED only)
//   dec_i          (RK_REVERSE_EN only) issue in descending round order
//   rk_ready_i     round datapath accepts the current beat
//   rk_valid_o     rk_data_o / rk_round_o / rk_last_o are valid
//   rk_data_o      current round key
//   rk_round_o     index of the current round key
//   rk_last_o      current beat is the final round key of the block
//   keys_loaded_o  shadow register holds a valid key set
//   busy_o         issuing in progress
//   done_o         one-cycle pulse after the final beat is accepted
//
// All outputs come straight from flops; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------------------------
module round_key_sequencer #(
    parameter int unsigned KW_W  = 1920,
    parameter int unsigned RK_W  = 128,
    parameter int unsigned RND_W = 4
) (
    input  logic             eph1_i,
    input  logic             reset_i,
    input  logic             key_done_i,
    input  logic [1:0]       key_size_i,
    input  logic [KW_W-1:0]  key_words_i,
    input  logic             start_i,
`ifdef RK_REVERSE_EN
    input  logic             dec_i,
`endif
    input  logic             rk_ready_i,
    output logic             rk_valid_o,
    output logic [RK_W-1:0]  rk_data_o,
    output logic [RND_W-1:0] rk_round_o,
    output logic             rk_last_o,
    output logic             keys_loaded_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned NumKeys = KW_W / RK_W;
    localparam int unsigned IdxW    = $clog2(NumKeys);

    typedef enum logic [1:0] {
        StIdle,
        StLoaded,
        StIssue,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Shadow key store, one packed slot per round key.
    logic [NumKeys-1:0][RK_W-1:0] keys_q, keys_d;
    logic [1:0]                   ksize_q, ksize_d;
    logic                         loaded_q, loaded_d;
    logic                         dec_q, dec_d;

    logic             rk_valid_q, rk_valid_d;
    logic [RK_W-1:0]  rk_data_q, rk_data_d;
    logic [RND_W-1:0] rk_round_q, rk_round_d;
    logic             rk_last_q, rk_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             dec_start;
    logic [RND_W-1:0] nr;
    logic [RND_W-1:0] nxt_round;
    logic [IdxW-1:0]  key_idx;
    logic             load_beat;
    logic             clear_beat;
    logic             beat_accept;

`ifdef RK_REVERSE_EN
    assign dec_start = dec_i;
`else
    assign dec_start = 1'b0;
`endif

    assign beat_accept = rk_valid_q & rk_ready_i;

    // Round count comes from the captured size, never the live input; 2'b11 counts as 256b.
    always_comb begin
        case (ksize_q)
            2'b00:   nr = RND_W'(10);
            2'b01:   nr = RND_W'(12);
            default: nr = RND_W'(14);
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge eph1_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next-state logic. key_done takes priority over everything, including a same-cycle
    // start, and aborts any block in flight.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (key_done_i) begin
            state_d = StLoaded;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StIdle;
                StLoaded: if (start_i) state_d = StIssue;
                StIssue:  if (beat_accept && rk_last_q) state_d = StDone;
                StDone:   state_d = StLoaded;
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: output logic. Produces the next value of every registered output so the beat that
    // follows an accepted beat is ready on the very next cycle (no bubbles at rk_ready=1).
    // -----------------------------------------------------------------------------------------
    always_comb begin
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        dec_d      = dec_q;
        nxt_round  = '0;
        load_beat  = 1'b0;
        clear_beat = 1'b0;

        if (key_done_i) begin
            clear_beat = 1'b1;
        end else begin
            unique case (state_q)
                StLoaded: begin
                    if (start_i) begin
                        load_beat = 1'b1;
                        dec_d     = dec_start;
                        nxt_round = dec_start ? nr : '0;
                    end
                end
                StIssue: begin
                    if (beat_accept) begin
                        if (rk_last_q) begin
                            clear_beat = 1'b1;
                        end else begin
                            load_beat = 1'b1;
                            nxt_round = dec_q ? (rk_round_q - 1'b1) : (rk_round_q + 1'b1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // Round i lives in slot NR-i, so round 0 is the highest used slot.
        key_idx = IdxW'(nr - nxt_round);

        if (clear_beat) begin
            rk_valid_d = 1'b0;
            rk_data_d  = '0;
            rk_round_d = '0;
            rk_last_d  = 1'b0;
        end else if (load_beat) begin
            rk_valid_d = 1'b1;
            rk_data_d  = keys_q[key_idx];
            rk_round_d = nxt_round;
            rk_last_d  = dec_d ? (nxt_round == '0) : (nxt_round == nr);
        end

        busy_d = (state_d == StIssue);
        done_d = (state_d == StDone);
    end

    // -----------------------------------------------------------------------------------------
    // Key capture. Upper slots unused by shorter keys are stored as-is and simply never indexed.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        keys_d   = keys_q;
        ksize_d  = ksize_q;
        loaded_d = loaded_q;
        if (key_done_i) begin
            keys_d   = key_words_i;
            ksize_d  = key_size_i;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge eph1_i or posedge reset_i) begin
        if (reset_i) begin
            keys_q   <= '0;
            ksize_q  <= 2'b00;
            loaded_q <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            keys_q   <= keys_d;
            ksize_q  <= ksize_d;
            loaded_q <= loaded_d;
            dec_q    <= dec_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge eph1_i or posedge reset_i) begin
        if (reset_i) begin
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_round_q <= '0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid_o    = rk_valid_q;
    assign rk_data_o     = rk_data_q;
    assign rk_round_o    = rk_round_q;
    assign rk_last_o     = rk_last_q;
    assign keys_loaded_o = loaded_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

    localparam int KW = 1920;

    localparam logic [127:0] Fips0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Fips1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] Fips10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K256_1  = 128'h1f352c073b6108d72d9810a30914dff4;

    logic           eph1 = 1'b0;
    logic           reset = 1'b1;
    logic           key_done = 1'b0;
    logic [1:0]     key_size = 2'b00;
    logic [KW-1:0]  key_words = '0;
    logic           start = 1'b0;
    logic           rk_ready = 1'b0;
`ifdef RK_REVERSE_EN
    logic           dec = 1'b0;
`endif
    logic           rk_valid;
    logic [127:0]   rk_data;
    logic [3:0]     rk_round;
    logic           rk_last;
    logic           keys_loaded;
    logic           busy;
    logic           done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] rk_tab [0:14];
    logic [127:0] obs    [0:14];

    round_key_sequencer dut (
        .eph1_i        (eph1),
        .reset_i       (reset),
        .key_done_i    (key_done),
        .key_size_i    (key_size),
        .key_words_i   (key_words),
        .start_i       (start),
`ifdef RK_REVERSE_EN
        .dec_i         (dec),
`endif
        .rk_ready_i    (rk_ready),
        .rk_valid_o    (rk_valid),
        .rk_data_o     (rk_data),
        .rk_round_o    (rk_round),
        .rk_last_o     (rk_last),
        .keys_loaded_o (keys_loaded),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 eph1 = ~eph1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    // Filler round keys unique per round and per key set.
    task automatic fill_tab(input logic [7:0] seed);
        for (int r = 0; r < 15; r++) begin
            rk_tab[r] = {4{seed, 8'(r), 16'ha55a}};
        end
    endtask

    // Round r goes to slot nr-r; slots above nr get junk that must never be issued.
    task automatic pack_keys(input int nr);
        for (int s = 0; s < 15; s++) begin
            if (s <= nr) key_words[s*128 +: 128] = rk_tab[nr - s];
            else         key_words[s*128 +: 128] = {8{16'hbeef}};
        end
    endtask

    task automatic load_key(input logic [1:0] size);
        key_size = size;
        key_done = 1'b1;
        tick();
        key_done = 1'b0;
    endtask

    task automatic push_block(input int nr, input bit rev);
        beat_t b;
        for (int k = 0; k <= nr; k++) begin
            int r;
            r       = rev ? (nr - k) : k;
            b.data  = rk_tab[r];
            b.round = 4'(r);
            b.last  = (k == nr);
            exp_q.push_back(b);
        end
    endtask

    // Issue one block; optionally stall for two cycles on stall_round.
    task automatic run_block(input string name, input int nr, input int stall_round,
                             input bit rev);
        int           cyc;
        int           beats;
        int           stall;
        bit           fin;
        beat_t        e;
        logic [127:0] held;
        exp_q.delete();
        push_block(nr, rev);
        for (int i = 0; i < 15; i++) obs[i] = 'x;
        held = '0;
        rk_ready = 1'b1;
`ifdef RK_REVERSE_EN
        dec = rev;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        n_assert++;
        if (rk_valid !== 1'b1 || rk_round !== 4'(rev ? nr : 0) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s first_beat: valid=%b round=%0d busy=%b, need valid=1 round=%0d busy=1",
                     name, rk_valid, rk_round, busy, rev ? nr : 0);
        end
        cyc = 0; beats = 0; stall = 0; fin = 1'b0;
        while (!fin && cyc < 60) begin
            if (rk_valid === 1'b1) begin
                if (stall_round >= 0 && int'(rk_round) == stall_round && stall > 0) begin
                    n_assert++;
                    if (rk_data !== held) begin
                        n_fail++;
                        $display("FAIL %s stall_hold: data=%h, need %h", name, rk_data, held);
                    end
                end
                if (stall_round >= 0 && int'(rk_round) == stall_round && stall < 2) begin
                    if (stall == 0) held = rk_data;
                    rk_ready = 1'b0;
                    stall++;
                end else begin
                    rk_ready = 1'b1;
                    n_assert++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_beat: round=%0d data=%h, need no beat",
                                 name, rk_round, rk_data);
                        fin = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        if (rk_data !== e.data || rk_round !== e.round || rk_last !== e.last) begin
                            n_fail++;
                            $display("FAIL %s beat%0d: round=%0d last=%b data=%h, need round=%0d last=%b data=%h",
                                     name, beats, rk_round, rk_last, rk_data, e.round, e.last,
                                     e.data);
                        end
                        obs[rk_round] = rk_data;
                        beats++;
                        if (rk_last === 1'b1) fin = 1'b1;
                    end
                end
            end
            tick();
            cyc++;
        end
        n_assert++;
        if (!fin || beats != nr + 1 || exp_q.size() != 0
            || cyc != nr + 1 + ((stall_round >= 0) ? 2 : 0)) begin
            n_fail++;
            $display("FAIL %s beat_count: beats=%0d cycles=%0d left=%0d, need beats=%0d cycles=%0d",
                     name, beats, cyc, exp_q.size(), nr + 1,
                     nr + 1 + ((stall_round >= 0) ? 2 : 0));
        end
        n_assert++;
        if (rk_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: valid=%b done=%b busy=%b, need 0 1 0",
                     name, rk_valid, done, busy);
        end
        tick();
        n_assert++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done=%b valid=%b, need 0 0", name, done, rk_valid);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_assert++;
        if ({rk_valid, rk_data, rk_round, rk_last, keys_loaded, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h round=%0d last=%b loaded=%b busy=%b done=%b, need all 0",
                     rk_valid, rk_data, rk_round, rk_last, keys_loaded, busy, done);
        end
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || keys_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start: valid=%b busy=%b loaded=%b, need 0 0 0",
                     rk_valid, busy, keys_loaded);
        end
    endtask

    task automatic test_fips128();
        fill_tab(8'h10);
        rk_tab[0]  = Fips0;
        rk_tab[1]  = Fips1;
        rk_tab[10] = Fips10;
        pack_keys(10);
        load_key(2'b00);
        n_assert++;
        if (keys_loaded !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load128: loaded=%b valid=%b, need 1 0", keys_loaded, rk_valid);
        end
        run_block("fips128", 10, -1, 1'b0);
        n_assert++;
        if (obs[0] !== Fips0 || obs[1] !== Fips1 || obs[10] !== Fips10) begin
            n_fail++;
            $display("FAIL fips128_vectors: r0=%h r1=%h r10=%h, need %h %h %h",
                     obs[0], obs[1], obs[10], Fips0, Fips1, Fips10);
        end
    endtask

    // Same held keys replayed with backpressure on round 3.
    task automatic test_backpressure();
        key_words = '1;
        run_block("backpressure", 10, 3, 1'b0);
        n_assert++;
        if (obs[3] !== rk_tab[3] || obs[10] !== Fips10) begin
            n_fail++;
            $display("FAIL bp_replay: r3=%h r10=%h, need %h %h", obs[3], obs[10], rk_tab[3],
                     Fips10);
        end
    endtask

    task automatic test_key_sizes();
        fill_tab(8'h92);
        pack_keys(12);
        load_key(2'b01);
        key_size = 2'b11;
        run_block("k192", 12, -1, 1'b0);
        fill_tab(8'h25);
        rk_tab[0] = K256_0;
        rk_tab[1] = K256_1;
        pack_keys(14);
        load_key(2'b11);
        key_size = 2'b00;
        run_block("k256", 14, -1, 1'b0);
        n_assert++;
        if (obs[0] !== K256_0 || obs[1] !== K256_1) begin
            n_fail++;
            $display("FAIL k256_vectors: r0=%h r1=%h, need %h %h", obs[0], obs[1], K256_0,
                     K256_1);
        end
    endtask

    task automatic test_abort();
        int cyc;
        fill_tab(8'h10);
        rk_tab[0] = Fips0;
        pack_keys(10);
        load_key(2'b00);
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (rk_round !== 4'd5 && cyc < 30) begin
            tick();
            cyc++;
        end
        n_assert++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd5 || rk_data !== rk_tab[5]) begin
            n_fail++;
            $display("FAIL abort_reach_r5: valid=%b round=%0d data=%h, need 1 5 %h",
                     rk_valid, rk_round, rk_data, rk_tab[5]);
        end
        fill_tab(8'h5a);
        pack_keys(14);
        key_size = 2'b10;
        key_done = 1'b1;
        tick();
        key_done = 1'b0;
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: valid=%b busy=%b done=%b, need 0 0 0", rk_valid, busy, done);
        end
        tick();
        n_assert++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b valid=%b, need 0 0", done, rk_valid);
        end
        run_block("abort_new_key", 14, -1, 1'b0);
        key_done = 1'b1;
        start = 1'b1;
        tick();
        key_done = 1'b0;
        start = 1'b0;
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL keydone_beats_start: valid=%b busy=%b, need 0 0", rk_valid, busy);
        end
        tick();
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_not_queued: valid=%b busy=%b, need 0 0", rk_valid, busy);
        end
    endtask

`ifdef RK_REVERSE_EN
    task automatic test_reverse();
        fill_tab(8'h10);
        rk_tab[0]  = Fips0;
        rk_tab[1]  = Fips1;
        rk_tab[10] = Fips10;
        pack_keys(10);
        load_key(2'b00);
        run_block("reverse", 10, -1, 1'b1);
        n_assert++;
        if (obs[10] !== Fips10 || obs[0] !== Fips0) begin
            n_fail++;
            $display("FAIL reverse_vectors: r10=%h r0=%h, need %h %h", obs[10], obs[0], Fips10,
                     Fips0);
        end
        run_block("forward_after_rev", 10, -1, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        fill_tab(8'h77);
        pack_keys(10);
        load_key(2'b00);
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_assert++;
        if ({rk_valid, rk_data, rk_round, rk_last, keys_loaded, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b data=%h round=%0d last=%b loaded=%b busy=%b done=%b, need all 0",
                     rk_valid, rk_data, rk_round, rk_last, keys_loaded, busy, done);
        end
        #1;
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || keys_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_then_start: valid=%b busy=%b loaded=%b, need 0 0 0",
                     rk_valid, busy, keys_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_backpressure();
        test_key_sizes();
        test_abort();
`ifdef RK_REVERSE_EN
        test_reverse();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
